multibyte_add_seq: RTL and testbench
====================================

# multibyte_add_seq

Sequential multi-byte adder controller that sits directly upstream of the 8-bit adder stage. It accepts two little-endian multi-byte operands one byte pair per handshake and drives the byte-wide add with the carry chained between bytes. It emits each result byte with its own valid/ready handshake and reports the final carry and signed overflow. Operand width is extended to N×8 bits without widening the adder datapath.

## Interface
- NBYTES, 4, number of bytes per operand (≥1).
- iClk  input  1  clock; all logic is on the rising edge.
- iRst  input  1  reset; synchronous, active-high.
- iStart  input  1  begins an operation; sampled in IDLE only.
- iCin  input  1  initial carry-in; latched with iStart.
- iData_a  input  8  operand A byte, LSB first.
- iData_b  input  8  operand B byte, LSB first.
- iValid  input  1  byte pair on iData_a/iData_b is valid.
- oReady  output  1  block accepts a byte pair this cycle.
- oData  output  8  result byte.
- oValid  output  1  oData is valid.
- iReady  input  1  downstream accepts oData.
- oCarry  output  1  final carry-out of the MS byte.
- oOverflow  output  1  signed overflow of the full-width sum.
- oBusy  output  1  high in RUN and DONE.
- oDone  output  1  one-cycle pulse when the operation completes.

## Operation
- States:
  - IDLE: iStart → RUN. carry_reg ← iCin, byte_cnt ← 0, oCarry ← 0, oOverflow ← 0.
  - RUN: accepts byte pairs. The accept of byte NBYTES-1 → DONE.
  - DONE: waits for the last result byte to be consumed, then pulses oDone and → IDLE.
- oReady = (state==RUN) && (!oValid || iReady). The output stage is a single-entry register.
- On accept (iValid && oReady):
  - sum[8:0] = iData_a + iData_b + carry_reg.
  - oData ← sum[7:0], oValid ← 1, carry_reg ← sum[8], byte_cnt++.
- Last-byte accept:
  - oCarry ← sum[8].
  - oOverflow ← (iData_a[7]==iData_b[7]) && (sum[7]!=iData_a[7]).
  - Both hold until the next iStart or reset.
- oValid clears on (oValid && iReady) unless a new byte is accepted in the same cycle.
- iStart in RUN or DONE is ignored. iValid outside RUN is ignored (oReady=0).
- NBYTES=1 goes IDLE → RUN → DONE after a single byte.
- Carry wraps out of the MS byte into oCarry only. The result width stays NBYTES×8; no extra byte is emitted.

## Timing
- Reset:
  - Takes effect on the first rising edge with iRst=1, including mid-operation.
  - State → IDLE; oData=0, oValid=0, oReady=0, oCarry=0, oOverflow=0, oBusy=0, oDone=0, carry_reg=0, byte_cnt=0.
  - A partial operation is discarded.
- iStart at edge t: oBusy=1 and oReady=1 from t+1.
- Latency is 1 cycle: a pair accepted at edge t gives oValid/oData at t+1.
- Throughput is 1 byte/cycle while iReady=1 is held.
- Backpressure: with oValid=1 and iReady=0, oReady=0 and oData is held stable. No byte is dropped or duplicated.
- oCarry/oOverflow are valid from the cycle after the last-byte accept, and no later than the last byte's oValid.
- oDone is high for exactly one cycle: the cycle after the last byte's (oValid && iReady). oBusy falls in the same cycle oDone rises.
- A new iStart is honoured from the cycle oDone is high (state is IDLE).

## Test plan
- NBYTES=4, cin=0, A=0x000000FF, B=0x00000001, iReady=1 → oData bytes 0x00,0x01,0x00,0x00 on consecutive cycles; oCarry=0, oOverflow=0; oDone pulses once.
- A=0xFFFFFFFF, B=0x00000001, cin=0 → bytes 0x00,0x00,0x00,0x00; oCarry=1, oOverflow=0.
- A=0x7F7F7F7F, B=0x7F7F7F7F, cin=1 → bytes 0xFF,0xFE,0xFE,0xFE; oCarry=0, oOverflow=1.
- Backpressure: A=0xAAAAAAAA, B=0x55555555, cin=0; hold iReady=0 for 3 cycles after the first oValid.
  - During the stall: oData stays 0xFF, oReady=0.
  - Final stream: 0xFF ×4 exactly; oCarry=0.
  - iStart pulsed during RUN has no effect.
- Reset after 2 of 4 bytes: every output is 0 on the next cycle and state is IDLE. A following op A=0x00000002, B=0x00000003 → bytes 0x05,0x00,0x00,0x00.
- NBYTES=1, A=0x80, B=0x80, cin=0 → single byte 0x00; oCarry=1, oOverflow=1; oDone pulses one cycle after the byte is consumed.

Source files
------------

// File: rtl/multibyte_add_seq.sv
// Sequential multi-byte adder: consumes little-endian byte pairs one per handshake,
// chains the carry through an 8-bit add and streams result bytes out with final carry/overflow.
module multibyte_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iStart,
  input  logic       iCin,
  input  logic [7:0] iData_a,
  input  logic [7:0] iData_b,
  input  logic       iValid,
  output logic       oReady,
  output logic [7:0] oData,
  output logic       oValid,
  input  logic       iReady,
  output logic       oCarry,
  output logic       oOverflow,
  output logic       oBusy,
  output logic       oDone
);

  localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           stateNext;
  logic             carryReg;
  logic [CNT_W-1:0] byteCnt;
  logic [8:0]       sum;
  logic             accept;
  logic             lastAccept;
  logic             drain;

  assign sum        = {1'b0, iData_a} + {1'b0, iData_b} + {8'd0, carryReg};
  assign accept     = iValid && oReady;
  assign lastAccept = accept && (byteCnt == LAST_IDX);
  assign drain      = oValid && iReady;

  // NOTE: reset is sampled inside the clocked block, so it only acts on a rising edge.
  always_ff @(posedge iClk) begin
    if (iRst) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (iStart)     stateNext = RUN;
      RUN:     if (lastAccept) stateNext = DONE;
      DONE:    if (drain)      stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // The single-entry output register may be refilled in the same cycle it drains.
  always_comb begin
    oReady = (state == RUN) && (!oValid || iReady);
    oBusy  = (state != IDLE);
  end

  // NOTE: every register here uses <= so all updates see the pre-edge values.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      carryReg  <= 1'b0;
      byteCnt   <= '0;
      oData     <= 8'd0;
      oValid    <= 1'b0;
      oCarry    <= 1'b0;
      oOverflow <= 1'b0;
      oDone     <= 1'b0;
    end else begin
      if (state == IDLE && iStart) begin
        carryReg  <= iCin;
        byteCnt   <= '0;
        oCarry    <= 1'b0;
        oOverflow <= 1'b0;
      end

      if (accept) begin
        oData    <= sum[7:0];
        oValid   <= 1'b1;
        carryReg <= sum[8];
        byteCnt  <= byteCnt + CNT_W'(1);
        if (lastAccept) begin
          oCarry    <= sum[8];
          oOverflow <= (iData_a[7] == iData_b[7]) && (sum[7] != iData_a[7]);
        end
      end else if (drain) begin
        oValid <= 1'b0;
      end

      // Completion is flagged once the final result byte has left the output register.
      oDone <= (state == DONE) && drain;
    end
  end

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Self-checking bench for multibyte_add_seq: NBYTES=4 and NBYTES=1 instances,
// scoreboard of expected result bytes derived from a full-width reference sum.
module tb_multibyte_add_seq;

  logic       iClk = 1'b0;
  logic       iRst;
  logic       iStart;
  logic       iCin;
  logic [7:0] iData_a;
  logic [7:0] iData_b;
  logic       iValid;
  logic       iReady;
  logic       sel;

  logic       ready4, valid4, carry4, ovf4, busy4, done4;
  logic [7:0] data4;
  logic       ready1, valid1, carry1, ovf1, busy1, done1;
  logic [7:0] data1;

  logic       obsReady, obsValid, obsCarry, obsOvf, obsBusy, obsDone;
  logic [7:0] obsData;

  int errors = 0;
  int checks = 0;
  logic [7:0] sbq[$];

  always #5 iClk = ~iClk;

  multibyte_add_seq #(.NBYTES(4)) dut4 (
    .iClk(iClk), .iRst(iRst), .iStart(iStart && !sel), .iCin(iCin),
    .iData_a(iData_a), .iData_b(iData_b), .iValid(iValid), .oReady(ready4),
    .oData(data4), .oValid(valid4), .iReady(iReady), .oCarry(carry4),
    .oOverflow(ovf4), .oBusy(busy4), .oDone(done4)
  );

  multibyte_add_seq #(.NBYTES(1)) dut1 (
    .iClk(iClk), .iRst(iRst), .iStart(iStart && sel), .iCin(iCin),
    .iData_a(iData_a), .iData_b(iData_b), .iValid(iValid), .oReady(ready1),
    .oData(data1), .oValid(valid1), .iReady(iReady), .oCarry(carry1),
    .oOverflow(ovf1), .oBusy(busy1), .oDone(done1)
  );

  always_comb begin
    obsReady = sel ? ready1 : ready4;
    obsData  = sel ? data1  : data4;
    obsValid = sel ? valid1 : valid4;
    obsCarry = sel ? carry1 : carry4;
    obsOvf   = sel ? ovf1   : ovf4;
    obsBusy  = sel ? busy1  : busy4;
    obsDone  = sel ? done1  : done4;
  end

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input int nb, input int stallLen, input bit pokeStart);
    logic [32:0] full;
    logic [7:0]  expByte;
    logic        expCarry;
    logic        expOvf;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int stallLeft = 0;
    bit seen = 0;
    bit stalled;
    full     = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    expCarry = full[8*nb];
    expOvf   = (a[8*nb-1] == b[8*nb-1]) && (full[8*nb-1] != a[8*nb-1]);
    sbq.delete();

    iReady = 1'b1;
    iValid = 1'b0;
    iCin   = cin;
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    #1;
    checks++;
    if (obsBusy !== 1'b1 || obsReady !== 1'b1) begin
      errors++;
      $display("FAIL %s start: busy=%b ready=%b, required 1/1", name, obsBusy, obsReady);
    end

    while (got < nb && cyc < 100) begin
      cyc++;
      if (obsValid && !seen) begin
        seen = 1;
        stallLeft = stallLen;
      end
      stalled = (stallLeft > 0);
      iReady  = !stalled;
      if (stalled) begin
        stallLeft--;
        iStart = pokeStart;
      end else begin
        iStart = 1'b0;
      end
      iValid = (sent < nb);
      if (sent < nb) begin
        iData_a = a[8*sent +: 8];
        iData_b = b[8*sent +: 8];
      end
      #1;

      if (stalled) begin
        checks++;
        if (obsReady !== 1'b0 || sbq.size() == 0 || obsData !== sbq[0]) begin
          errors++;
          $display("FAIL %s stall: ready=%b data=%h, required ready=0 data held", name, obsReady, obsData);
        end
      end

      if (obsValid && iReady) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL %s extra byte: data=%h, required none", name, obsData);
        end else begin
          expByte = sbq.pop_front();
          if (obsData !== expByte) begin
            errors++;
            $display("FAIL %s byte%0d: got %h, required %h", name, got, obsData, expByte);
          end
        end
        got++;
        if (got == nb) begin
          checks++;
          if (obsCarry !== expCarry || obsOvf !== expOvf) begin
            errors++;
            $display("FAIL %s flags: carry=%b ovf=%b, required %b/%b", name, obsCarry, obsOvf, expCarry, expOvf);
          end
        end
      end

      if (iValid && obsReady) begin
        sbq.push_back(full[8*sent +: 8]);
        sent++;
      end
      @(negedge iClk);
    end

    iValid = 1'b0;
    iReady = 1'b1;
    iStart = 1'b0;
    if (got < nb) begin
      errors++;
      $display("FAIL %s timeout: got %0d bytes, required %0d", name, got, nb);
    end
    #1;
    checks++;
    if (obsDone !== 1'b1 || obsBusy !== 1'b0 || obsValid !== 1'b0 || sbq.size() != 0) begin
      errors++;
      $display("FAIL %s done: done=%b busy=%b valid=%b pending=%0d, required 1/0/0/0",
               name, obsDone, obsBusy, obsValid, sbq.size());
    end
    if (stallLen == 0) begin
      checks++;
      if (cyc != nb + 1) begin
        errors++;
        $display("FAIL %s throughput: %0d cycles, required %0d", name, cyc, nb + 1);
      end
    end
    @(negedge iClk);
    #1;
    checks++;
    if (obsDone !== 1'b0 || obsCarry !== expCarry || obsOvf !== expOvf) begin
      errors++;
      $display("FAIL %s hold: done=%b carry=%b ovf=%b, required 0/%b/%b", name, obsDone, obsCarry, obsOvf, expCarry, expOvf);
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    iRst = 1'b1;
    repeat (2) @(negedge iClk);
    #1;
    checks++;
    if ({obsData, obsValid, obsReady, obsCarry, obsOvf, obsBusy, obsDone} !== 14'd0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset: data=%h v=%b r=%b c=%b o=%b b=%b d=%b, required all 0",
               obsData, obsValid, obsReady, obsCarry, obsOvf, obsBusy, obsDone);
    end
    iRst = 1'b0;
    @(negedge iClk);
  endtask

  task automatic test_basic();
    sel = 1'b0;
    run_op("inc", 32'h0000_00FF, 32'h0000_0001, 1'b0, 4, 0, 0);
    run_op("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4, 0, 0);
    run_op("ovf", 32'h7F7F_7F7F, 32'h7F7F_7F7F, 1'b1, 4, 0, 0);
  endtask

  task automatic test_backpressure();
    sel = 1'b0;
    run_op("bp", 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 4, 3, 1);
  endtask

  task automatic test_mid_reset();
    sel = 1'b0;
    iReady = 1'b1;
    iCin   = 1'b0;
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    for (int i = 0; i < 2; i++) begin
      iValid  = 1'b1;
      iData_a = 8'h11;
      iData_b = 8'h22;
      @(negedge iClk);
    end
    iValid = 1'b0;
    iRst   = 1'b1;
    @(negedge iClk);
    #1;
    checks++;
    if ({obsData, obsValid, obsReady, obsCarry, obsOvf, obsBusy, obsDone} !== 14'd0) begin
      errors++;
      $display("FAIL midreset: data=%h v=%b r=%b c=%b o=%b b=%b d=%b, required all 0",
               obsData, obsValid, obsReady, obsCarry, obsOvf, obsBusy, obsDone);
    end
    iRst = 1'b0;
    @(negedge iClk);
    run_op("after_rst", 32'h0000_0002, 32'h0000_0003, 1'b0, 4, 0, 0);
  endtask

  task automatic test_single_byte();
    sel = 1'b1;
    @(negedge iClk);
    run_op("nb1", 32'h0000_0080, 32'h0000_0080, 1'b0, 1, 0, 0);
    sel = 1'b0;
  endtask

  initial begin
    iRst = 1'b1; iStart = 1'b0; iCin = 1'b0; iData_a = 8'd0; iData_b = 8'd0;
    iValid = 1'b0; iReady = 1'b1; sel = 1'b0;
    @(negedge iClk);
    test_reset();
    test_basic();
    test_backpressure();
    test_mid_reset();
    test_single_byte();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
